seven_segment_reader: RTL and testbench

Reads a multiplexed seven-segment display bus (segments A..G plus one-hot digit strobes) from an external module or panel. Recovers one BCD digit per strobe position. Requires each digit's pattern to be stable before capturing it. Assembles a full frame of DIGITS digits and presents it on a valid/ready handshake. Sits downstream of the segment drivers in display loop-back and self-test paths.

---
 rtl/seven_segment_reader_pkg.sv | 25 ++
 rtl/seven_segment_reader_if.sv | 24 ++
 rtl/seven_segment_pattern_decode.sv | 32 +++
 rtl/seven_segment_reader.sv | 134 +++++++++++++
 tb/tb_seven_segment_reader.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seven_segment_reader_pkg.sv
// Shared constants and types for the seven-segment bus reader.
// Segment order is A..G from bit 6 down to bit 0, active-high.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_ERR   = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/seven_segment_reader_if.sv
// Bundle of the display bus inputs and the frame output handshake.
// A frame transfers on every rising clock edge where frame_valid && frame_ready;
// while frame_valid is high and no transfer has happened, frame_bcd/frame_err are stable.
interface seven_segment_reader_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg;
    logic [DIGITS-1:0]   dig_en;
    logic                frame_ready;
    logic                frame_valid;
    logic [4*DIGITS-1:0] frame_bcd;
    logic [DIGITS-1:0]   frame_err;
    logic                overrun;

    modport master (
        output seg, dig_en, frame_ready,
        input  frame_valid, frame_bcd, frame_err, overrun
    );

    modport slave (
        input  seg, dig_en, frame_ready,
        output frame_valid, frame_bcd, frame_err, overrun
    );
endinterface

// File: rtl/seven_segment_pattern_decode.sv
// Combinational segment pattern to BCD code decoder.
// Build option SEG_READER_BLANK_EN: an all-dark pattern decodes to CODE_BLANK without error.
module seven_segment_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       err
);
    always_comb begin
        code = CODE_ERR;
        err  = 1'b1;
        case (pattern)
            SEG_0: begin code = 4'd0; err = 1'b0; end
            SEG_1: begin code = 4'd1; err = 1'b0; end
            SEG_2: begin code = 4'd2; err = 1'b0; end
            SEG_3: begin code = 4'd3; err = 1'b0; end
            SEG_4: begin code = 4'd4; err = 1'b0; end
            SEG_5: begin code = 4'd5; err = 1'b0; end
            SEG_6: begin code = 4'd6; err = 1'b0; end
            SEG_7: begin code = 4'd7; err = 1'b0; end
            SEG_8: begin code = 4'd8; err = 1'b0; end
            SEG_9: begin code = 4'd9; err = 1'b0; end
`ifdef SEG_READER_BLANK_EN
            SEG_BLANK: begin code = CODE_BLANK; err = 1'b0; end
`else
            SEG_BLANK: begin code = CODE_ERR; err = 1'b1; end
`endif
            default: begin code = CODE_ERR; err = 1'b1; end
        endcase
    end
endmodule

// File: rtl/seven_segment_reader.sv
// Recovers BCD frames from a multiplexed seven-segment bus and hands them out on valid/ready.
// Optional build macro SEG_READER_BLANK_EN (handled in seven_segment_pattern_decode).
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seven_segment_reader_if.slave  bus,
    output state_t                 dbg_state
);
    localparam int              CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   STABLE_MAX = CW'(STABLE_CYCLES);

    logic [6:0]          seg_s1, seg_s2, seg_prev;
    logic [DIGITS-1:0]   en_s1, en_s2, en_prev;
    logic [CW-1:0]       cnt, cnt_next;
    logic                onehot, changed, capture;
    logic [3:0]          dec_code;
    logic                dec_err;
    logic [DIGITS-1:0]   mask;
    logic [4*DIGITS-1:0] work_bcd, frame_bcd_q;
    logic [DIGITS-1:0]   work_err, frame_err_q;
    logic                overrun_q;
    logic                mask_full, handshake, load, drop, frame_valid;
    state_t              state, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            seg_prev <= '0;
            en_s1    <= '0;
            en_s2    <= '0;
            en_prev  <= '0;
            cnt      <= '0;
        end else begin
            seg_s1   <= bus.seg;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            en_s1    <= bus.dig_en;
            en_s2    <= en_s1;
            en_prev  <= en_s2;
            cnt      <= cnt_next;
        end
    end

    // A new dwell starts whenever the sample changes, so a saturated counter
    // that restarts at 1 must still be allowed to capture when STABLE_CYCLES is 1.
    always_comb begin
        onehot  = $onehot(en_s2);
        changed = (seg_s2 != seg_prev) || (en_s2 != en_prev);
        if (!onehot)
            cnt_next = '0;
        else if (changed)
            cnt_next = CW'(1);
        else if (cnt != STABLE_MAX)
            cnt_next = cnt + CW'(1);
        else
            cnt_next = cnt;
        capture = onehot && (cnt_next == STABLE_MAX) && (changed || (cnt != STABLE_MAX));
    end

    seven_segment_pattern_decode u_decode (
        .pattern (seg_s2),
        .code    (dec_code),
        .err     (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask     <= '0;
            work_bcd <= '0;
            work_err <= '0;
        end else begin
            mask <= (mask_full ? '0 : mask) | (capture ? en_s2 : '0);
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && en_s2[i]) begin
                    work_bcd[4*i +: 4] <= dec_code;
                    work_err[i]        <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (mask_full) state_next = HOLD;
            HOLD:    if (!mask_full && handshake) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // A frame finishing while one is still unaccepted is dropped, unless the
    // held frame leaves on this very edge, in which case the new one replaces it.
    always_comb begin
        mask_full   = &mask;
        frame_valid = (state == HOLD);
        handshake   = frame_valid && bus.frame_ready;
        load        = mask_full && ((state == COLLECT) || handshake);
        drop        = mask_full && (state == HOLD) && !handshake;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_bcd_q <= '0;
            frame_err_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (load) begin
                frame_bcd_q <= work_bcd;
                frame_err_q <= work_err;
            end
            if (drop)
                overrun_q <= 1'b1;
        end
    end

    assign bus.frame_valid = frame_valid;
    assign bus.frame_bcd   = frame_bcd_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun     = overrun_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with DIGITS=4, STABLE_CYCLES=3.
// Honours SEG_READER_BLANK_EN for the blank-digit expectation.
module tb_seven_segment_reader;
    import seven_segment_pkg::*;

`ifdef SEG_READER_BLANK_EN
    localparam logic [3:0] EXP_BLANK_CODE = 4'hA;
    localparam logic       EXP_BLANK_ERR  = 1'b0;
`else
    localparam logic [3:0] EXP_BLANK_CODE = 4'hF;
    localparam logic       EXP_BLANK_ERR  = 1'b1;
`endif

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     n_cmp;
    int     n_err;

    seven_segment_reader_if #(.DIGITS(4)) bus ();

    seven_segment_reader #(
        .DIGITS        (4),
        .STABLE_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a pattern/strobe pair and advance n falling edges.
    task automatic show(input logic [6:0] p, input logic [3:0] en, input int n);
        bus.seg    = p;
        bus.dig_en = en;
        repeat (n) @(negedge clk);
    endtask

    // Each digit dwells 5 cycles; returns 5 falling edges after the last digit appeared.
    task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3);
        show(p0, 4'b0001, 5);
        show(p1, 4'b0010, 5);
        show(p2, 4'b0100, 5);
        show(p3, 4'b1000, 5);
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        rst_n           = 1'b1;
        bus.seg         = '0;
        bus.dig_en      = '0;
        bus.frame_ready = 1'b1;
        @(negedge clk);

        // Reset asserted while the bus is active
        show(SEG_7, 4'b0010, 3);
        rst_n = 1'b0;
        show(SEG_3, 4'b0001, 2);
        check("rst_valid",   32'(bus.frame_valid), 32'h0);
        check("rst_bcd",     32'(bus.frame_bcd),   32'h0);
        check("rst_err",     32'(bus.frame_err),   32'h0);
        check("rst_overrun", 32'(bus.overrun),     32'h0);
        check("rst_state",   32'(dbg_state),       32'(COLLECT));
        rst_n = 1'b1;
        show(7'h00, 4'b0000, 3);

        // Basic frame 1,2,3,4 with latency 2 + 3 + 1
        send_frame(SEG_1, SEG_2, SEG_3, SEG_4);
        check("lat_early", 32'(bus.frame_valid), 32'h0);
        show(7'h00, 4'b0000, 1);
        check("f1_valid", 32'(bus.frame_valid), 32'h1);
        check("f1_bcd",   32'(bus.frame_bcd),   32'h4321);
        check("f1_err",   32'(bus.frame_err),   32'h0);
        show(7'h00, 4'b0000, 1);
        check("f1_single", 32'(bus.frame_valid), 32'h0);

        // Glitching digit 0 never reaches the stability threshold
        for (int k = 0; k < 6; k++)
            show((k % 2 == 1) ? SEG_1 : SEG_0, 4'b0001, 2);
        show(SEG_5, 4'b0010, 5);
        show(SEG_6, 4'b0100, 5);
        show(SEG_7, 4'b1000, 5);
        show(7'h00, 4'b0000, 3);
        check("glitch_no_cap", 32'(bus.frame_valid), 32'h0);
        show(SEG_8, 4'b0001, 5);
        show(7'h00, 4'b0000, 1);
        check("glitch_valid", 32'(bus.frame_valid), 32'h1);
        check("glitch_bcd",   32'(bus.frame_bcd),   32'h7658);
        show(7'h00, 4'b0000, 1);

        // Strobes that are not one-hot never capture
        show(SEG_0, 4'b0011, 10);
        show(SEG_0, 4'b0000, 10);
        show(SEG_1, 4'b0010, 5);
        show(SEG_2, 4'b0100, 5);
        show(SEG_3, 4'b1000, 5);
        show(7'h00, 4'b0000, 3);
        check("nonhot_no_cap", 32'(bus.frame_valid), 32'h0);
        show(SEG_0, 4'b0001, 5);
        show(7'h00, 4'b0000, 1);
        check("nonhot_valid", 32'(bus.frame_valid), 32'h1);
        check("nonhot_bcd",   32'(bus.frame_bcd),   32'h3210);
        show(7'h00, 4'b0000, 1);

        // Undecodable and blanked digits
        send_frame(SEG_0, SEG_9, 7'b1000001, SEG_BLANK);
        show(7'h00, 4'b0000, 1);
        check("dec_valid", 32'(bus.frame_valid), 32'h1);
        check("dec_bcd",   32'(bus.frame_bcd),   32'({EXP_BLANK_CODE, 4'hF, 4'h9, 4'h0}));
        check("dec_err",   32'(bus.frame_err),   32'({EXP_BLANK_ERR, 3'b100}));
        show(7'h00, 4'b0000, 1);

        // Consumer stalls across two frames: second is dropped
        bus.frame_ready = 1'b0;
        send_frame(SEG_5, SEG_6, SEG_7, SEG_8);
        show(7'h00, 4'b0000, 1);
        check("ovr_first_valid", 32'(bus.frame_valid), 32'h1);
        check("ovr_first_bcd",   32'(bus.frame_bcd),   32'h8765);
        check("ovr_first_flag",  32'(bus.overrun),     32'h0);
        show(7'h00, 4'b0000, 4);
        check("ovr_hold_valid", 32'(bus.frame_valid), 32'h1);
        send_frame(SEG_0, SEG_0, SEG_0, SEG_0);
        show(7'h00, 4'b0000, 1);
        check("ovr_flag",   32'(bus.overrun),     32'h1);
        check("ovr_bcd",    32'(bus.frame_bcd),   32'h8765);
        check("ovr_valid",  32'(bus.frame_valid), 32'h1);
        check("ovr_state",  32'(dbg_state),       32'(HOLD));
        bus.frame_ready = 1'b1;
        show(7'h00, 4'b0000, 1);
        check("ovr_hs_valid", 32'(bus.frame_valid), 32'h0);
        check("ovr_sticky",   32'(bus.overrun),     32'h1);

        // Overrun clears on reset only
        rst_n = 1'b0;
        show(7'h00, 4'b0000, 2);
        check("ovr_reset", 32'(bus.overrun), 32'h0);
        rst_n = 1'b1;
        show(7'h00, 4'b0000, 3);

        // New frame completes on the exact handshake edge
        bus.frame_ready = 1'b0;
        send_frame(SEG_4, SEG_3, SEG_2, SEG_1);
        show(7'h00, 4'b0000, 1);
        check("same_first_bcd", 32'(bus.frame_bcd), 32'h1234);
        send_frame(SEG_6, SEG_7, SEG_8, SEG_9);
        bus.frame_ready = 1'b1;
        show(7'h00, 4'b0000, 1);
        check("same_valid",   32'(bus.frame_valid), 32'h1);
        check("same_bcd",     32'(bus.frame_bcd),   32'h9876);
        check("same_overrun", 32'(bus.overrun),     32'h0);
        show(7'h00, 4'b0000, 1);
        check("same_drop", 32'(bus.frame_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
